uart_tx: RTL and testbench

UART serial transmitter: the transmit-side counterpart of the team's UART receiver (start-check / sampler / parity-check chain).
- Accepts a parallel word with a single-cycle valid strobe and serialises it as: start bit, data LSB first, optional parity bit, stop bit.
- Clocked at the bit rate: one Clk cycle per serial bit, no oversampling.
- Sits between the system-side register/FIFO interface and the TX pad.

---
 rtl/uart_tx.sv | 165 ++++++++++++++++
 tb/tb_uart_tx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter clocked at the bit rate: start bit, DATA_WIDTH data bits LSB first,
// optional parity bit, stop bit. Define UART_TX_HOLD_BUF_EN to add a one-word hold buffer and the Buf_Full output.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
`ifdef UART_TX_HOLD_BUF_EN
  ,
  output logic                  Buf_Full
`endif
);

  // state  | meaning
  // IDLE   | line high, waiting for a word
  // START  | start bit (0) on the line
  // DATA   | data bit cnt on the line
  // PARITY | parity bit on the line
  // STOP   | stop bit (1) on the line
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [DATA_WIDTH-1:0]   shreg;
  logic                    par_en_q;
  logic                    par_bit_q;
  logic                    in_par;

`ifdef UART_TX_HOLD_BUF_EN
  logic [DATA_WIDTH-1:0]   buf_data;
  logic                    buf_par_en;
  logic                    buf_par_bit;
`endif

  // Parity is resolved at capture time so later input changes cannot affect it.
  assign in_par = (^P_DATA) ^ PAR_TYP;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      TX_OUT    <= 1'b1;
      Busy      <= 1'b0;
`ifdef UART_TX_HOLD_BUF_EN
      buf_data    <= '0;
      buf_par_en  <= 1'b0;
      buf_par_bit <= 1'b0;
      Buf_Full    <= 1'b0;
`endif
    end else begin
`ifdef UART_TX_HOLD_BUF_EN
      if (Busy && Data_Valid && !Buf_Full) begin
        buf_data    <= P_DATA;
        buf_par_en  <= PAR_EN;
        buf_par_bit <= in_par;
        Buf_Full    <= 1'b1;
      end
`endif
      case (state)
        IDLE: begin
          TX_OUT <= 1'b1;
          Busy   <= 1'b0;
`ifdef UART_TX_HOLD_BUF_EN
          // A word captured on the final STOP edge is still waiting here.
          if (Buf_Full) begin
            shreg     <= buf_data;
            par_en_q  <= buf_par_en;
            par_bit_q <= buf_par_bit;
            Buf_Full  <= Data_Valid;
            if (Data_Valid) begin
              buf_data    <= P_DATA;
              buf_par_en  <= PAR_EN;
              buf_par_bit <= in_par;
            end
            TX_OUT <= 1'b0;
            Busy   <= 1'b1;
            state  <= START;
          end else
`endif
          if (Data_Valid) begin
            shreg     <= P_DATA;
            par_en_q  <= PAR_EN;
            par_bit_q <= in_par;
            TX_OUT    <= 1'b0;
            Busy      <= 1'b1;
            state     <= START;
          end
        end

        START: begin
          TX_OUT <= shreg[0];
          shreg  <= shreg >> 1;
          cnt    <= '0;
          state  <= DATA;
        end

        DATA: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (par_en_q) begin
              TX_OUT <= par_bit_q;
              state  <= PARITY;
            end else begin
              TX_OUT <= 1'b1;
              state  <= STOP;
            end
          end else begin
            TX_OUT <= shreg[0];
            shreg  <= shreg >> 1;
            cnt    <= cnt + CW'(1);
          end
        end

        PARITY: begin
          TX_OUT <= 1'b1;
          state  <= STOP;
        end

        STOP: begin
`ifdef UART_TX_HOLD_BUF_EN
          if (Buf_Full) begin
            shreg     <= buf_data;
            par_en_q  <= buf_par_en;
            par_bit_q <= buf_par_bit;
            Buf_Full  <= Data_Valid;
            if (Data_Valid) begin
              buf_data    <= P_DATA;
              buf_par_en  <= PAR_EN;
              buf_par_bit <= in_par;
            end
            TX_OUT <= 1'b0;
            Busy   <= 1'b1;
            state  <= START;
          end else
`endif
          begin
            TX_OUT <= 1'b1;
            Busy   <= 1'b0;
            state  <= IDLE;
          end
        end

        default: begin
          TX_OUT <= 1'b1;
          Busy   <= 1'b0;
          cnt    <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: constant frame table, directed corner sequences and a queue-based line model under random stimulus.
module tb_uart_tx;
  localparam int DW = 8;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic [DW-1:0] P_DATA = '0;
  logic          Data_Valid = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          TX_OUT;
  logic          Busy;
`ifdef UART_TX_HOLD_BUF_EN
  logic          Buf_Full;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  uart_tx #(.DATA_WIDTH(DW)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .P_DATA(P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP),
    .TX_OUT(TX_OUT),
    .Busy(Busy)
`ifdef UART_TX_HOLD_BUF_EN
    ,
    .Buf_Full(Buf_Full)
`endif
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          pe;
    logic          pt;
    int            len;
    logic [10:0]   bits;   // bit c = expected line level c cycles after the strobe edge
  } vec_t;

  vec_t vecs[6];

  // Line model: bits still to appear, one per edge, plus the hold buffer when built in.
  bit mq[$];
  bit m_busy;
`ifdef UART_TX_HOLD_BUF_EN
  logic [DW-1:0] mb_d;
  bit mb_pe, mb_pt, mb_full;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic strobe(input logic [DW-1:0] d, input logic pe, input logic pt);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0;
  endtask

  task automatic check_idle(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check($sformatf("%s idle tx %0d", nm, i), TX_OUT, 1'b1);
      check($sformatf("%s idle busy %0d", nm, i), Busy, 1'b0);
    end
  endtask

  task automatic push_frame(input logic [DW-1:0] d, input bit pe, input bit pt);
    mq.push_back(1'b0);
    for (int i = 0; i < DW; i++) mq.push_back(d[i]);
    if (pe) mq.push_back((^d) ^ pt);
    mq.push_back(1'b1);
  endtask

  task automatic model_step(input bit dv, input logic [DW-1:0] d, input bit pe, input bit pt,
                            output bit etx, output bit ebusy);
    bit stop_edge;
    stop_edge = m_busy && (mq.size() == 0);
`ifdef UART_TX_HOLD_BUF_EN
    if ((!m_busy || stop_edge) && mb_full) begin
      push_frame(mb_d, mb_pe, mb_pt);
      if (dv) begin mb_d = d; mb_pe = pe; mb_pt = pt; end
      else mb_full = 1'b0;
    end else if (!m_busy && dv) begin
      push_frame(d, pe, pt);
    end else if (m_busy && dv && !mb_full) begin
      mb_d = d; mb_pe = pe; mb_pt = pt; mb_full = 1'b1;
    end
`else
    if (!m_busy && dv) push_frame(d, pe, pt);
`endif
    if (mq.size() > 0) begin
      etx = mq.pop_front();
      ebusy = 1'b1;
    end else begin
      etx = 1'b1;
      ebusy = 1'b0;
    end
    m_busy = ebusy;
  endtask

  initial begin
    bit etx, ebusy;
    bit dv, pe, pt;
    logic [DW-1:0] d;
    logic [9:0] f3c, f81, f12, f34;

    vecs[0] = '{8'hA5, 1'b1, 1'b0, 11, 11'b10101001010};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 11, 11'b11101001010};
    vecs[2] = '{8'h00, 1'b0, 1'b0, 10, 11'b01000000000};
    vecs[3] = '{8'h3C, 1'b0, 1'b1, 10, 11'b01001111000};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 11, 11'b11111111110};
    vecs[5] = '{8'h01, 1'b1, 1'b0, 11, 11'b11000000010};
    f3c = 10'b1001111000;
    f81 = 10'b1100000010;
    f12 = 10'b1000100100;
    f34 = 10'b1001101000;

    // Asynchronous reset, checked before any clock edge.
    #2 Rst = 1'b0;
    #1;
    check("reset tx", TX_OUT, 1'b1);
    check("reset busy", Busy, 1'b0);
`ifdef UART_TX_HOLD_BUF_EN
    check("reset buf_full", Buf_Full, 1'b0);
`endif
    tick();
    Rst = 1'b1;
    check_idle("post-reset", 3);

    // Table vectors; inputs are scrambled mid-frame and must not matter.
    for (int v = 0; v < 6; v++) begin
      strobe(vecs[v].data, vecs[v].pe, vecs[v].pt);
      for (int c = 0; c < vecs[v].len; c++) begin
        if (c > 0) tick();
        check($sformatf("vec%0d tx c%0d", v, c), TX_OUT, vecs[v].bits[c]);
        check($sformatf("vec%0d busy c%0d", v, c), Busy, 1'b1);
        if (c == 3) begin
          P_DATA = DW'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
        end
      end
      check_idle($sformatf("vec%0d", v), 2);
    end

    // Reset during data bit 3 aborts the frame at once.
    strobe(8'hA5, 1'b1, 1'b0);
    for (int c = 1; c <= 4; c++) tick();
    #2 Rst = 1'b0;
    #1;
    check("midframe reset tx", TX_OUT, 1'b1);
    check("midframe reset busy", Busy, 1'b0);
    tick();
    Rst = 1'b1;
    check_idle("after midframe reset", 15);

`ifndef UART_TX_HOLD_BUF_EN
    // Strobe during a frame is dropped.
    strobe(8'h3C, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) tick();
      check($sformatf("drop tx c%0d", c), TX_OUT, f3c[c]);
      check($sformatf("drop busy c%0d", c), Busy, 1'b1);
      if (c == 2) begin P_DATA = 8'hFF; Data_Valid = 1'b1; end
      else Data_Valid = 1'b0;
    end
    check_idle("drop", 15);

    // Data_Valid held high: one frame per 11 cycles with one idle cycle.
    P_DATA = 8'h81; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    for (int i = 0; i < 33; i++) begin
      tick();
      if ((i % 11) < 10) begin
        check($sformatf("held tx %0d", i), TX_OUT, f81[i % 11]);
        check($sformatf("held busy %0d", i), Busy, 1'b1);
      end else begin
        check($sformatf("held gap tx %0d", i), TX_OUT, 1'b1);
        check($sformatf("held gap busy %0d", i), Busy, 1'b0);
      end
    end
    Data_Valid = 1'b0;
    check_idle("held end", 3);
`else
    // Hold buffer: second word follows with no gap, third is dropped.
    strobe(8'h12, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      if (c > 0) tick();
      check($sformatf("hold tx c%0d", c), TX_OUT, (c < 10) ? f12[c] : f34[c-10]);
      check($sformatf("hold busy c%0d", c), Busy, 1'b1);
      if (c >= 1) check($sformatf("hold full c%0d", c), Buf_Full, (c < 10) ? 1'b1 : 1'b0);
      if (c == 0) begin P_DATA = 8'h34; Data_Valid = 1'b1; end
      else if (c == 1) begin P_DATA = 8'h56; Data_Valid = 1'b1; end
      else Data_Valid = 1'b0;
    end
    check_idle("hold end", 4);
    check("hold end buf_full", Buf_Full, 1'b0);
`endif

    // Random traffic against the line model.
    Rst = 1'b0;
    tick();
    Rst = 1'b1;
    mq.delete();
    m_busy = 1'b0;
`ifdef UART_TX_HOLD_BUF_EN
    mb_full = 1'b0; mb_d = '0; mb_pe = 1'b0; mb_pt = 1'b0;
`endif
    dv = ($urandom_range(0, 3) == 0); d = DW'($urandom); pe = 1'($urandom); pt = 1'($urandom);
    Data_Valid = dv; P_DATA = d; PAR_EN = pe; PAR_TYP = pt;
    for (int i = 0; i < 600; i++) begin
      tick();
      model_step(dv, d, pe, pt, etx, ebusy);
      check($sformatf("rand tx %0d", i), TX_OUT, etx);
      check($sformatf("rand busy %0d", i), Busy, ebusy);
`ifdef UART_TX_HOLD_BUF_EN
      check($sformatf("rand full %0d", i), Buf_Full, mb_full);
`endif
      dv = ($urandom_range(0, 3) == 0); d = DW'($urandom); pe = 1'($urandom); pt = 1'($urandom);
      Data_Valid = dv; P_DATA = d; PAR_EN = pe; PAR_TYP = pt;
    end
    Data_Valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
